// File: rtl/jpeg_byte_stuffer_pkg.sv
// Shared types and constants for the JPEG output byte stuffer.
// Holds marker bytes, data_valid codes, FSM states and the FIFO entry layout.
package jpeg_pkg;

  localparam logic [7:0] SOI_HI     = 8'hFF;
  localparam logic [7:0] SOI_LO     = 8'hD8;
  localparam logic [7:0] EOI_LO     = 8'hD9;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] FF_BYTE    = 8'hFF;

  localparam logic [1:0] DV_NONE     = 2'b00;
  localparam logic [1:0] DV_WORD     = 2'b01;
  localparam logic [1:0] DV_LAST     = 2'b10;
  localparam logic [1:0] DV_WORD_ALT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SOI_FF,
    SOI_D8,
    SEND,
    STUFF,
    EOI_FF,
    EOI_D9
  } state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_entry_t;

  // Byte 0 is the most significant byte, i.e. the first one on the wire.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jpeg_byte_stuffer_if.sv
// Word-in / byte-out bus of the byte stuffer; slave is the stuffer itself.
interface jpeg_byte_stuffer_if;

  logic [31:0] jpeg_bitstream;
  logic [1:0]  data_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        eoi_done;
  logic        overflow;

  modport master (
    output jpeg_bitstream, data_valid, byte_ready,
    input  byte_out, byte_valid, eoi_done, overflow
  );

  modport slave (
    input  jpeg_bitstream, data_valid, byte_ready,
    output byte_out, byte_valid, eoi_done, overflow
  );

endinterface

// File: rtl/jpeg_byte_stuffer_word_fifo.sv
// Synchronous word FIFO with registered occupancy count.
// Push when full and pop when empty are ignored; dout shows the head entry.
module jpeg_word_fifo
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              din,
  output fifo_entry_t              dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Serialises buffered 32-bit entropy words MSB-first into a byte stream,
// stuffing 0x00 after data 0xFF bytes and framing each image with SOI/EOI.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_byte_stuffer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state_q, state_d;
  logic [31:0]   sh_q, sh_d;
  logic          last_q, last_d;
  logic [1:0]    idx_q, idx_d;
  logic          soi_pend_q, soi_pend_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          eoi_done_q, eoi_done_d;
  logic          overflow_q, overflow_d;

  logic          in_vld;
  logic          fifo_push, fifo_pop;
  fifo_entry_t   fifo_din, fifo_dout;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;

  logic          fire, advance, load;

  jpeg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    in_vld        = (bus.data_valid != DV_NONE);
    fifo_push     = in_vld && !fifo_full;
    fifo_din.last = (bus.data_valid == DV_LAST);
    fifo_din.word = bus.jpeg_bitstream;
    // A drop is judged on the registered count, so a same-cycle pop does not save it.
    overflow_d    = overflow_q || (in_vld && (fifo_count == CW'(DEPTH)));
  end

  always_comb begin
    fire         = byte_valid_q && bus.byte_ready;
    advance      = 1'b0;
    load         = 1'b0;
    fifo_pop     = 1'b0;
    state_d      = state_q;
    sh_d         = sh_q;
    last_d       = last_q;
    idx_d        = idx_q;
    soi_pend_d   = soi_pend_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    eoi_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (soi_pend_q) begin
            state_d      = SOI_FF;
            byte_out_d   = SOI_HI;
            byte_valid_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      SOI_FF: begin
        if (fire) begin
          state_d    = SOI_D8;
          byte_out_d = SOI_LO;
        end
      end
      SOI_D8: begin
        if (fire) begin
          soi_pend_d = 1'b0;
          load       = 1'b1;
        end
      end
      SEND: begin
        if (fire) begin
          if (byte_out_q == FF_BYTE) begin
            state_d    = STUFF;
            byte_out_d = STUFF_BYTE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      STUFF: begin
        if (fire) advance = 1'b1;
      end
      EOI_FF: begin
        if (fire) begin
          state_d    = EOI_D9;
          byte_out_d = EOI_LO;
        end
      end
      EOI_D9: begin
        if (fire) begin
          eoi_done_d   = 1'b1;
          soi_pend_d   = 1'b1;
          state_d      = IDLE;
          byte_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        byte_valid_d = 1'b0;
      end
    endcase

    // Move past the current data byte (a stuffed 0x00 lands here too).
    if (advance) begin
      if (idx_q != 2'd3) begin
        idx_d      = idx_q + 2'd1;
        byte_out_d = word_byte(sh_q, idx_q + 2'd1);
        state_d    = SEND;
      end else if (last_q) begin
        state_d    = EOI_FF;
        byte_out_d = SOI_HI;
      end else if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        state_d      = IDLE;
        byte_valid_d = 1'b0;
      end
    end

    // Pulling the head word straight into the output keeps words gap-free.
    if (load) begin
      fifo_pop     = 1'b1;
      sh_d         = fifo_dout.word;
      last_d       = fifo_dout.last;
      idx_d        = 2'd0;
      byte_out_d   = word_byte(fifo_dout.word, 2'd0);
      byte_valid_d = 1'b1;
      state_d      = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      last_q       <= 1'b0;
      idx_q        <= '0;
      soi_pend_q   <= 1'b1;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      eoi_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      soi_pend_q   <= soi_pend_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      eoi_done_q   <= eoi_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.eoi_done   = eoi_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Directed bench for jpeg_byte_stuffer: framing, stuffing, back-pressure,
// overflow, multi-image and mid-word reset, checked against hand-built byte lists.
module tb_jpeg_byte_stuffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_byte_stuffer_if bus();

  jpeg_byte_stuffer #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          eoi_cnt = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  bit          bp_pat[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]  prev_out;
  logic        prev_v;
  logic [31:0] w;
  logic        found;

  // Accepted bytes and eoi pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.byte_out);
      if (bus.eoi_done) eoi_cnt <= eoi_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic push_word(input logic [31:0] word, input logic [1:0] code);
    bus.jpeg_bitstream = word;
    bus.data_valid     = code;
    @(posedge clk); #1;
    bus.data_valid     = 2'b00;
  endtask

  task automatic wait_eoi(input int target, input string tag);
    int n = 0;
    while (eoi_cnt < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_eoi"}, eoi_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.jpeg_bitstream = '0;
    bus.data_valid     = 2'b00;
    bus.byte_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_byte_valid", bus.byte_valid, 1'b0);
    chk("rst_byte_out",   bus.byte_out,   8'h00);
    chk("rst_eoi_done",   bus.eoi_done,   1'b0);
    chk("rst_overflow",   bus.overflow,   1'b0);

    // Single image, plus SOI latency.
    got_q.delete();
    push_word(32'h12345678, 2'b10);
    chk("lat_soi_pre",   bus.byte_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_soi_valid", bus.byte_valid, 1'b1);
    chk("lat_soi_byte",  bus.byte_out,   8'hFF);
    wait_eoi(1, "single");
    exp_q = '{8'hFF, 8'hD8, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hD9};
    chk_stream("single");

    // Stuffing; second word arrives with FSM idle and no SOI pending.
    got_q.delete();
    push_word(32'hFF00FFAB, 2'b01);
    repeat (12) @(posedge clk);
    #1;
    chk("stuff_idle", bus.byte_valid, 1'b0);
    push_word(32'h11223344, 2'b10);
    chk("lat_data_pre", bus.byte_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_data_valid", bus.byte_valid, 1'b1);
    chk("lat_data_byte",  bus.byte_out,   8'h11);
    wait_eoi(2, "stuff");
    exp_q = '{8'hFF, 8'hD8, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB,
              8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hD9};
    chk_stream("stuff");

    // Back-pressure: output must hold while not ready.
    got_q.delete();
    push_word(32'hA1B2C3D4, 2'b10);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      bus.byte_ready = bp_pat[i];
      prev_out = bus.byte_out;
      prev_v   = bus.byte_valid;
      @(posedge clk); #1;
      if (!bp_pat[i] && prev_v) begin
        chk($sformatf("bp_hold_byte%0d", i),  bus.byte_out,   prev_out);
        chk($sformatf("bp_hold_valid%0d", i), bus.byte_valid, 1'b1);
      end
    end
    bus.byte_ready = 1'b1;
    wait_eoi(3, "bp");
    exp_q = '{8'hFF, 8'hD8, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFF, 8'hD9};
    chk_stream("bp");

    // Overflow: nine pushes while stalled, the ninth is dropped.
    got_q.delete();
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w = 32'h01020304 + k * 32'h10101010;
      push_word(w, (k >= 7) ? 2'b10 : 2'b01);
      if (k == 7) chk("ovf_before", bus.overflow, 1'b0);
      if (k == 8) chk("ovf_set",    bus.overflow, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", bus.overflow, 1'b1);
    bus.byte_ready = 1'b1;
    wait_eoi(4, "ovf");
    chk("ovf_after_drain", bus.overflow, 1'b1);
    exp_q = '{8'hFF, 8'hD8};
    for (int k = 0; k < 8; k++) begin
      w = 32'h01020304 + k * 32'h10101010;
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    chk_stream("ovf");

    // Two images back to back.
    got_q.delete();
    push_word(32'h0A0B0C0D, 2'b10);
    push_word(32'h1A1B1C1D, 2'b10);
    wait_eoi(6, "two_img");
    exp_q = '{8'hFF, 8'hD8, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF, 8'hD9,
              8'hFF, 8'hD8, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'hFF, 8'hD9};
    chk_stream("two_img");

    // Reset one cycle after byte 1 of a word is accepted.
    got_q.delete();
    push_word(32'h55667788, 2'b01);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready && bus.byte_out == 8'h66) found = 1'b1;
    end
    chk("rst_mid_seen", found, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid",    bus.byte_valid, 1'b0);
    chk("rst_mid_overflow", bus.overflow,   1'b0);
    chk("rst_mid_byte",     bus.byte_out,   8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_quiet", bus.byte_valid, 1'b0);
    got_q.delete();
    push_word(32'h01020304, 2'b10);
    wait_eoi(7, "rst_mid");
    exp_q = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hD9};
    chk_stream("rst_mid");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
